gshare_bht: RTL and testbench
=============================

# gshare_bht

Parametrised successor to the 2-bit branch history table. It adds configurable counter width, gshare indexing (PC XOR global history) and a sequential flush/initialisation walker, so the storage needs no reset and maps to RAM. It sits in the frontend beside the BTB/RAS, predicts every slot of a fetch block from `vpc_i`, and is trained by resolved branches from execute.

## Interface
- `VLEN`, 64: virtual address width.
- `INSTR_PER_FETCH`, 2: prediction slots per fetch block; power of two.
- `RVC`, 1: compressed instructions enabled. Sets OFFSET=1 when 1, OFFSET=2 when 0.
- `NR_ENTRIES`, 1024: total counters; NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH, power of two, at least 2.
- `CTR_BITS`, 2: saturating counter width, legal range 2..4.
- `GHR_BITS`, 8: global history length, 0..log2(NR_ROWS). A value of 0 gives a pure bimodal table.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `flush_bp_i`  in  1  request to invalidate the whole table.
- `debug_mode_i`  in  1  when high, updates are dropped.
- `vpc_i`  in  VLEN  fetch block address.
- `update_valid_i`  in  1  resolved-branch update strobe.
- `update_pc_i`  in  VLEN  PC of the resolved branch.
- `update_taken_i`  in  1  resolved direction.
- `pred_valid_o`  out  INSTR_PER_FETCH  per-slot entry valid.
- `pred_taken_o`  out  INSTR_PER_FETCH  per-slot predicted taken.
- `flush_busy_o`  out  1  walker active.
- `ghr_o`  out  max(GHR_BITS,1)  current history, for debug and trace.

## Operation
- **Index fields.**
  - RB = log2(NR_ROWS); SB = log2(INSTR_PER_FETCH).
  - Row = pc[RB+SB+OFFSET-1 : SB+OFFSET] XOR zero-extended GHR (history in the low bits).
  - Slot = pc[SB+OFFSET-1 : OFFSET] when RVC=1, otherwise 0.
- **Entry format.** Each entry is {valid, ctr[CTR_BITS-1:0]}. INIT = 1 << (CTR_BITS-1), i.e. weakly taken.
- **Prediction.** Combinational from the registered table.
  - `pred_valid_o[i]` = entry[row(vpc_i)][i].valid.
  - `pred_taken_o[i]` = that entry's ctr MSB.
  - While `flush_busy_o`=1, both outputs are forced to 0.
- **Update acceptance.** An update is accepted when `update_valid_i` && !`debug_mode_i` && !`flush_busy_o`.
- **Accepted update.**
  - Entry [row(update_pc_i), using GHR before the shift][slot] gets valid=1.
  - ctr increments on taken, saturating at 2^CTR_BITS-1.
  - ctr decrements on not-taken, saturating at 0.
  - Same edge: GHR <= {GHR[GHR_BITS-2:0], update_taken_i}. There is no GHR when GHR_BITS=0.
- **Dropped update.** Neither the table nor the GHR changes.
- **Flush walker FSM.**
  - States: IDLE, FLUSH; counter `fcnt` of RB bits.
  - IDLE --`flush_bp_i`--> FLUSH: fcnt=0, GHR=0.
  - In FLUSH, each cycle writes every slot of row fcnt to {0, INIT} and increments fcnt.
  - After the write of row NR_ROWS-1, the FSM goes to IDLE.
  - `flush_bp_i` during FLUSH restarts the walk: fcnt=0, GHR=0.
- **Reset.**
  - Reset puts the FSM in FLUSH with fcnt=0 and GHR=0. Table contents are not reset; the walk initialises them.
  - Reset-time output values: `flush_busy_o`=1, `pred_valid_o`=0, `pred_taken_o`=0, `ghr_o`=0.
  - Reset asserted mid-walk or mid-update aborts immediately and the walk restarts on release.
- **Storage write arbitration.** Flush writes have priority. Updates are never accepted while busy, so at most one write occurs per cycle.

## Timing
- Prediction has 0-cycle latency from `vpc_i` and `ghr_o`.
- An update accepted at edge N is visible to predictions and GHR from cycle N+1.
- Same-cycle read of an entry being updated returns the pre-update value.
- `flush_bp_i` sampled at edge N: `flush_busy_o`=1 from N+1 through N+NR_ROWS, then 0.
- After reset release, `flush_busy_o` stays high for exactly NR_ROWS cycles.
- An update presented in the cycle `flush_busy_o` falls is accepted.
- No backpressure: an update dropped while busy or in debug mode is lost, not queued.

## Test plan
- **Reset walk.**
  - Config: NR_ENTRIES=16, IPF=2, RVC=1, CTR_BITS=2, GHR_BITS=3.
  - Release reset -> `flush_busy_o`=1 for 8 cycles with all predictions 0.
  - Then busy=0, and every vpc gives valid=0, taken=1.
- **Saturation.**
  - Config: GHR_BITS=0, CTR_BITS=2.
  - 4 taken updates at pc 0x4 -> slot0 valid=1, taken=1, ctr=11 (4th held).
  - 2 not-taken updates -> ctr=01, taken=0.
  - 2 more not-taken -> ctr=00 held.
- **Gshare indexing.**
  - Config: GHR_BITS=3, GHR=0.
  - 3 taken updates at pc 0x100 -> rows 0, 1, 3 written; `ghr_o`=3'b111.
  - vpc 0x100 (row 7) -> slot0 valid=0.
  - vpc 0x18 (row 6^7=1) -> slot0 valid=1, taken=1.
- **Debug / busy drop.**
  - Update with `debug_mode_i`=1 -> table and `ghr_o` unchanged.
  - Update during a walk -> dropped. Update in the cycle busy falls -> applied.
- **Flush restart.**
  - `flush_bp_i` at edge k and again at k+3 -> busy continuously high, falls after edge k+3+8.
  - GHR reads 0 afterwards, and all entries are valid=0, ctr=INIT.
- **Read/write collision.**
  - vpc_i equal to update_pc_i's row/slot in an updating cycle -> old prediction that cycle, new value the next cycle.
  - Repeat with CTR_BITS=4: INIT=1000 gives taken=1; 8 not-taken updates saturate ctr at 0000.

Source files
------------

// File: rtl/gshare_bht.sv
// gshare branch history table: PC^GHR-indexed saturating counters, predicting
// every slot of a fetch block, with a row-by-row flush walker so that the
// storage itself carries no reset and can map onto RAM.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | table usable; predictions live; updates accepted
// S_FLUSH | walker writing {invalid, INIT} to row fcnt each cycle; outputs 0
module gshare_bht #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned RVC             = 1,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned GHR_BITS        = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_bp_i,
  input  logic                                     debug_mode_i,
  input  logic [VLEN-1:0]                          vpc_i,
  input  logic                                     update_valid_i,
  input  logic [VLEN-1:0]                          update_pc_i,
  input  logic                                     update_taken_i,
  output logic [INSTR_PER_FETCH-1:0]               pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0]               pred_taken_o,
  output logic                                     flush_busy_o,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] ghr_o
);

  localparam int unsigned OFFSET  = (RVC == 1) ? 1 : 2;
  localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned RB      = $clog2(NR_ROWS);
  localparam int unsigned SB      = $clog2(INSTR_PER_FETCH);
  localparam int unsigned SW      = (SB > 0) ? SB : 1;
  localparam int unsigned GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int unsigned EW      = CTR_BITS + 1;

  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [EW-1:0]       ENTRY_FLUSH = {1'b0, CTR_INIT};

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [RB-1:0]   fcnt_q, fcnt_d;
  logic [GW-1:0]   ghr_q, ghr_d;

  // Storage: entry = {valid, ctr}; no reset, initialised by the walker.
  logic [EW-1:0]   tbl_q [NR_ROWS][INSTR_PER_FETCH];

  logic                       busy;
  logic                       upd_acc;
  logic [RB-1:0]              upd_row;
  logic [SW-1:0]              upd_slot;
  logic [EW-1:0]              upd_entry;
  logic [CTR_BITS-1:0]        upd_ctr;
  logic [RB-1:0]              pred_row;
  logic                       wr_en;
  logic [RB-1:0]              wr_row;
  logic [INSTR_PER_FETCH-1:0] wr_mask;
  logic [EW-1:0]              wr_entry;

  // Only the index field of each PC is used; the rest is deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i, update_pc_i};

  // Row index: PC index field XOR history held in the low bits.
  function automatic logic [RB-1:0] row_of(input logic [VLEN-1:0] pc,
                                           input logic [GW-1:0]   ghr);
    logic [RB-1:0] hist;
    hist = (GHR_BITS == 0) ? '0 : RB'(ghr);
    return RB'(pc >> (SB + OFFSET)) ^ hist;
  endfunction

  // Slot within the fetch block; without RVC all branches land in slot 0.
  function automatic logic [SW-1:0] slot_of(input logic [VLEN-1:0] pc);
    if (RVC == 0 || SB == 0) return '0;
    return SW'(pc >> OFFSET);
  endfunction

  assign busy         = (state_q == S_FLUSH);
  assign flush_busy_o = busy;
  assign ghr_o        = ghr_q;
  assign upd_acc      = update_valid_i && !debug_mode_i && !busy;

  // Walker state, flush counter and global history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FLUSH;
      fcnt_q  <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ghr_q   <= ghr_d;
    end
  end

  // Next state: walk rows to the end, a flush request (re)starts from row 0.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    ghr_d   = ghr_q;
    if (upd_acc && GHR_BITS > 0) begin
      ghr_d = GW'({ghr_q, update_taken_i});
    end
    case (state_q)
      S_IDLE: ;
      S_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == RB'(NR_ROWS - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_FLUSH;
    endcase
    if (flush_bp_i) begin
      state_d = S_FLUSH;
      fcnt_d  = '0;
      ghr_d   = '0;
    end
  end

  // Update path: read-modify-write of the addressed counter, saturating.
  always_comb begin
    upd_row   = row_of(update_pc_i, ghr_q);
    upd_slot  = slot_of(update_pc_i);
    upd_entry = tbl_q[upd_row][upd_slot];
    upd_ctr   = upd_entry[CTR_BITS-1:0];
    if (update_taken_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr = upd_ctr - 1'b1;
    end
  end

  // Write arbitration: the walker owns the port while busy, which is also
  // exactly when updates are refused, so there is never more than one write.
  always_comb begin
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_mask  = '0;
    wr_entry = ENTRY_FLUSH;
    if (busy) begin
      wr_en   = 1'b1;
      wr_row  = fcnt_q;
      wr_mask = '1;
    end else if (upd_acc) begin
      wr_en             = 1'b1;
      wr_row            = upd_row;
      wr_mask[upd_slot] = 1'b1;
      wr_entry          = {1'b1, upd_ctr};
    end
  end

  // Table storage write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
        if (wr_mask[i]) tbl_q[wr_row][i] <= wr_entry;
      end
    end
  end

  // Prediction: combinational read of the whole row, blanked during a walk.
  always_comb begin
    pred_row     = row_of(vpc_i, ghr_q);
    pred_valid_o = '0;
    pred_taken_o = '0;
    if (!busy) begin
      for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
        pred_valid_o[i] = tbl_q[pred_row][i][CTR_BITS];
        pred_taken_o[i] = tbl_q[pred_row][i][CTR_BITS-1];
      end
    end
  end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: three instances (gshare 2-bit, bimodal 2-bit,
// bimodal 4-bit) share one stimulus; each scenario checks the instance it targets.
module tb_gshare_bht;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [31:0] vpc_i = '0;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;

  logic [1:0] a_pv, a_pt, b_pv, b_pt, c_pv, c_pt;
  logic       a_busy, b_busy, c_busy;
  logic [2:0] a_ghr;
  logic [0:0] b_ghr, c_ghr;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  gshare_bht #(.VLEN(32), .INSTR_PER_FETCH(2), .RVC(1), .NR_ENTRIES(16),
               .CTR_BITS(2), .GHR_BITS(3)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i), .vpc_i(vpc_i), .update_valid_i(update_valid_i),
    .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .pred_valid_o(a_pv), .pred_taken_o(a_pt), .flush_busy_o(a_busy), .ghr_o(a_ghr));

  gshare_bht #(.VLEN(32), .INSTR_PER_FETCH(2), .RVC(1), .NR_ENTRIES(16),
               .CTR_BITS(2), .GHR_BITS(0)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i), .vpc_i(vpc_i), .update_valid_i(update_valid_i),
    .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .pred_valid_o(b_pv), .pred_taken_o(b_pt), .flush_busy_o(b_busy), .ghr_o(b_ghr));

  gshare_bht #(.VLEN(32), .INSTR_PER_FETCH(2), .RVC(1), .NR_ENTRIES(16),
               .CTR_BITS(4), .GHR_BITS(0)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i), .vpc_i(vpc_i), .update_valid_i(update_valid_i),
    .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .pred_valid_o(c_pv), .pred_taken_o(c_pt), .flush_busy_o(c_busy), .ghr_o(c_ghr));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One accepted-or-not update presented for exactly one clock edge.
  task automatic upd(input logic [31:0] pc, input logic taken);
    update_valid_i = 1'b1;
    update_pc_i    = pc;
    update_taken_i = taken;
    step();
    update_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    flush_bp_i = 1'b0;
    debug_mode_i = 1'b0;
    update_valid_i = 1'b0;
    rst_ni = 1'b0;
    #13;
    @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    while ((a_busy || b_busy || c_busy) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL reset_timeout busy still high after %0d cycles, required low", n);
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst_ni = 1'b0;
    vpc_i = 32'h6;
    #12;
    checks++;
    if ({a_busy, a_pv, a_pt, a_ghr} !== {1'b1, 2'b00, 2'b00, 3'b000}) begin
      failures++;
      $display("FAIL reset_outputs busy/pv/pt/ghr=%b/%b/%b/%b, required 1/00/00/000",
               a_busy, a_pv, a_pt, a_ghr);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    bad = 0;
    while (a_busy && n < 40) begin
      vpc_i = n * 4;
      #1;
      if (a_pv !== 2'b00 || a_pt !== 2'b00) bad++;
      @(posedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL reset_walk_len busy cycles=%0d, required 8", n);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL busy_preds_zero nonzero predictions in %0d busy cycles, required 0", bad);
    end
    for (int r = 0; r < 8; r++) begin
      vpc_i = r << 2;
      #1;
      checks++;
      if ({a_pv, a_pt, b_pv, b_pt, c_pv, c_pt} !== 12'b00_11_00_11_00_11) begin
        failures++;
        $display("FAIL post_walk_row%0d a=%b/%b b=%b/%b c=%b/%b, required 00/11 each",
                 r, a_pv, a_pt, b_pv, b_pt, c_pv, c_pt);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    vpc_i = 32'h4;
    repeat (4) upd(32'h4, 1'b1);
    checks++;
    if ({b_pv, b_pt} !== 4'b01_11) begin
      failures++;
      $display("FAIL sat_top pv/pt=%b/%b, required 01/11", b_pv, b_pt);
    end
    upd(32'h4, 1'b0);
    checks++;
    if (b_pt[0] !== 1'b1) begin
      failures++;
      $display("FAIL sat_top_held taken=%b, required 1 (ctr 10)", b_pt[0]);
    end
    upd(32'h4, 1'b0);
    checks++;
    if (b_pt[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_nt2 taken=%b, required 0 (ctr 01)", b_pt[0]);
    end
    upd(32'h4, 1'b0);
    upd(32'h4, 1'b0);
    upd(32'h4, 1'b1);
    checks++;
    if (b_pt[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_bottom_held taken=%b, required 0 (ctr 01)", b_pt[0]);
    end
    upd(32'h4, 1'b1);
    checks++;
    if ({b_pv[0], b_pt[0], b_ghr} !== 3'b110) begin
      failures++;
      $display("FAIL sat_recover valid/taken/ghr=%b/%b/%b, required 1/1/0",
               b_pv[0], b_pt[0], b_ghr);
    end
  endtask

  task automatic test_gshare();
    do_reset();
    repeat (3) upd(32'h100, 1'b1);
    checks++;
    if (a_ghr !== 3'b111) begin
      failures++;
      $display("FAIL gshare_ghr ghr=%b, required 111", a_ghr);
    end
    vpc_i = 32'h100;
    #1;
    checks++;
    if (a_pv[0] !== 1'b0) begin
      failures++;
      $display("FAIL gshare_row7 valid=%b, required 0", a_pv[0]);
    end
    vpc_i = 32'h18;
    #1;
    checks++;
    if ({a_pv[0], a_pt[0]} !== 2'b11) begin
      failures++;
      $display("FAIL gshare_row1 valid/taken=%b/%b, required 1/1", a_pv[0], a_pt[0]);
    end
    vpc_i = 32'h10;
    #1;
    checks++;
    if ({a_pv[0], a_pt[0]} !== 2'b11) begin
      failures++;
      $display("FAIL gshare_row3 valid/taken=%b/%b, required 1/1", a_pv[0], a_pt[0]);
    end
    vpc_i = 32'h1C;
    #1;
    checks++;
    if ({a_pv[0], a_pt[0]} !== 2'b11) begin
      failures++;
      $display("FAIL gshare_row0 valid/taken=%b/%b, required 1/1", a_pv[0], a_pt[0]);
    end
    vpc_i = 32'h14;
    #1;
    checks++;
    if (a_pv !== 2'b00) begin
      failures++;
      $display("FAIL gshare_row2 valid=%b, required 00", a_pv);
    end
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    debug_mode_i = 1'b1;
    upd(32'h100, 1'b1);
    debug_mode_i = 1'b0;
    vpc_i = 32'h0;
    #1;
    checks++;
    if ({a_ghr, a_pv} !== 5'b000_00) begin
      failures++;
      $display("FAIL debug_drop ghr/pv=%b/%b, required 000/00", a_ghr, a_pv);
    end
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    step();
    step();
    upd(32'h0, 1'b1);
    checks++;
    if ({a_busy, a_ghr} !== 4'b1_000) begin
      failures++;
      $display("FAIL busy_drop busy/ghr=%b/%b, required 1/000", a_busy, a_ghr);
    end
    n = 0;
    while (a_busy && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL flush_walk_len remaining busy cycles=%0d, required 5", n);
    end
    vpc_i = 32'h0;
    #1;
    checks++;
    if (a_pv !== 2'b00) begin
      failures++;
      $display("FAIL busy_drop_table row0 valid=%b, required 00", a_pv);
    end
    upd(32'h0, 1'b1);
    checks++;
    if (a_ghr !== 3'b001) begin
      failures++;
      $display("FAIL fall_edge_ghr ghr=%b, required 001", a_ghr);
    end
    vpc_i = 32'h4;
    #1;
    checks++;
    if ({a_pv, a_pt} !== 4'b01_11) begin
      failures++;
      $display("FAIL fall_edge_entry pv/pt=%b/%b, required 01/11", a_pv, a_pt);
    end
  endtask

  task automatic test_restart();
    int n;
    logic hi;
    do_reset();
    repeat (3) upd(32'h100, 1'b1);
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    hi = a_busy;
    step();
    hi = hi & a_busy;
    step();
    hi = hi & a_busy;
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    hi = hi & a_busy;
    n = 0;
    while (a_busy && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (hi !== 1'b1) begin
      failures++;
      $display("FAIL restart_busy_high busy dipped=%b, required continuous 1", hi);
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL restart_len busy cycles after restart=%0d, required 8", n);
    end
    checks++;
    if (a_ghr !== 3'b000) begin
      failures++;
      $display("FAIL restart_ghr ghr=%b, required 000", a_ghr);
    end
    for (int r = 0; r < 8; r++) begin
      vpc_i = r << 2;
      #1;
      checks++;
      if ({a_pv, a_pt} !== 4'b00_11) begin
        failures++;
        $display("FAIL restart_row%0d pv/pt=%b/%b, required 00/11", r, a_pv, a_pt);
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    vpc_i = 32'h6;
    update_pc_i = 32'h6;
    update_taken_i = 1'b0;
    update_valid_i = 1'b1;
    #1;
    checks++;
    if ({b_pv[1], b_pt[1]} !== 2'b01) begin
      failures++;
      $display("FAIL coll_old valid/taken=%b/%b, required 0/1", b_pv[1], b_pt[1]);
    end
    step();
    update_valid_i = 1'b0;
    checks++;
    if ({b_pv[1], b_pt[1]} !== 2'b10) begin
      failures++;
      $display("FAIL coll_new valid/taken=%b/%b, required 1/0", b_pv[1], b_pt[1]);
    end
    vpc_i = 32'hA;
    update_pc_i = 32'hA;
    update_taken_i = 1'b0;
    update_valid_i = 1'b1;
    #1;
    checks++;
    if ({c_pv[1], c_pt[1]} !== 2'b01) begin
      failures++;
      $display("FAIL c4_coll_old valid/taken=%b/%b, required 0/1", c_pv[1], c_pt[1]);
    end
    step();
    update_valid_i = 1'b0;
    checks++;
    if ({c_pv[1], c_pt[1]} !== 2'b10) begin
      failures++;
      $display("FAIL c4_coll_new valid/taken=%b/%b, required 1/0", c_pv[1], c_pt[1]);
    end
    repeat (8) upd(32'hA, 1'b0);
    repeat (7) upd(32'hA, 1'b1);
    checks++;
    if (c_pt[1] !== 1'b0) begin
      failures++;
      $display("FAIL c4_floor taken=%b, required 0 (ctr 0111)", c_pt[1]);
    end
    upd(32'hA, 1'b1);
    checks++;
    if ({c_pv[1], c_pt[1]} !== 2'b11) begin
      failures++;
      $display("FAIL c4_mid valid/taken=%b/%b, required 1/1 (ctr 1000)", c_pv[1], c_pt[1]);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_saturation();
    test_gshare();
    test_drop();
    test_restart();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
